// File: rtl/seven_seg_scanner.sv
// Multiplexed 4-digit seven-segment scanner with double-buffered digit data,
// an anti-ghost guard interval at the start of every slot and frame-aligned data swaps.
module seven_seg_scanner #(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned GUARD       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] digits_in [3:0],
    input  logic       update,
    input  logic [3:0] blank_in,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_done
);

    localparam int unsigned     CntW     = $clog2(REFRESH_DIV);
    localparam logic [CntW-1:0] CntMax   = CntW'(REFRESH_DIV - 1);
    localparam logic [CntW-1:0] CntGuard = CntW'(GUARD);

    logic [3:0][3:0] stage_q, stage_d;
    logic [3:0][3:0] active_q, active_d;
    logic [3:0]      stage_mask_q, stage_mask_d;
    logic [3:0]      active_mask_q, active_mask_d;
    logic            pending_q, pending_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic [3:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            frame_done_q, frame_done_d;
    logic            boundary;

    // Active-low cathodes, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        unique case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_comb begin
        cnt_d         = cnt_q + CntW'(1);
        idx_d         = idx_q;
        boundary      = (cnt_q == CntMax) && (idx_q == 2'd3);
        stage_d       = stage_q;
        stage_mask_d  = stage_mask_q;
        active_d      = active_q;
        active_mask_d = active_mask_q;
        pending_d     = pending_q;
        an_d          = 4'b1111;
        seg_d         = 7'b1111111;
        frame_done_d  = boundary;

        if (cnt_q == CntMax) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end

        if (boundary && pending_q) begin
            active_d      = stage_q;
            active_mask_d = stage_mask_q;
            pending_d     = 1'b0;
        end

        // Evaluated after the swap so a coincident update stays pending for the next frame.
        if (update) begin
            for (int i = 0; i < 4; i++) begin
                stage_d[i] = digits_in[i];
            end
            stage_mask_d = blank_in;
            pending_d    = 1'b1;
        end

        if (cnt_q >= CntGuard) begin
            an_d = ~(4'b0001 << idx_q);
            if (!active_mask_q[idx_q]) begin
                seg_d = decode(active_q[idx_q]);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage_q       <= '0;
            stage_mask_q  <= '0;
            active_q      <= '0;
            active_mask_q <= '0;
            pending_q     <= 1'b0;
            cnt_q         <= '0;
            idx_q         <= '0;
            an_q          <= 4'b1111;
            seg_q         <= 7'b1111111;
            frame_done_q  <= 1'b0;
        end else begin
            stage_q       <= stage_d;
            stage_mask_q  <= stage_mask_d;
            active_q      <= active_d;
            active_mask_q <= active_mask_d;
            pending_q     <= pending_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = 1'b1;
    assign frame_done = frame_done_q;

endmodule

// File: doc/seven_seg_scanner.md
SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 Parameter REFRESH_DIV, default 50000, is the number of clk cycles per digit slot; it SHALL be at least GUARD+2.
REQ-002 Parameter GUARD, default 4, is the number of anti-ghost cycles at the start of each slot with all anodes off; it SHALL be at least 1.
REQ-003 clk  input  1  is the single clock, rising-edge active.
REQ-004 reset  input  1  is the asynchronous, active-low reset.
REQ-005 digits_in  input  4x4 (unpacked [3:0] of [3:0])  carries the controller display_out nibbles; index 3 is the leftmost digit.
REQ-006 update  input  1  is a one-cycle strobe that captures digits_in and blank_in.
REQ-007 blank_in  input  4  is a per-digit blank mask; 1 forces that digit dark.
REQ-008 an  output  4  is the active-low anode select; an[i] drives digit i.
REQ-009 seg  output  7  is the active-low cathodes, ordered {g,f,e,d,c,b,a}.
REQ-010 dp  output  1  is the active-low decimal point; it SHALL be constant 1 (off).
REQ-011 frame_done  output  1  SHALL pulse for one cycle at the end of each 4-digit frame.

Function
REQ-012 The block SHALL hold a staging register set (4 nibbles plus a 4-bit mask), an active register set, a pending flag, a slot counter cnt (0..REFRESH_DIV-1) and a digit index idx (0..3).
REQ-013 When update=1, staging SHALL load digits_in and blank_in on that clock edge, and pending SHALL be set.
REQ-014 cnt SHALL increment every cycle; at REFRESH_DIV-1 it SHALL wrap to 0, and idx SHALL advance as 0->1->2->3->0.
REQ-015 The frame boundary is cnt==REFRESH_DIV-1 with idx==3; at that edge frame_done SHALL be 1 for that cycle only.
REQ-016 On a frame boundary with pending=1, active SHALL load staging and pending SHALL clear; active SHALL never change at any other time, so a frame is never torn.
REQ-017 If update and the frame boundary coincide, active SHALL take the old staging, staging SHALL take the new inputs, and pending SHALL remain 1.
REQ-018 an, seg and frame_done SHALL be registered outputs and SHALL reflect the cnt/idx state of the previous cycle.
REQ-019 While cnt<GUARD: an=4'b1111 and seg=7'b1111111.
REQ-020 While cnt>=GUARD: an SHALL be the one-cold code for idx, and seg SHALL be the decode of active digit[idx], or 7'b1111111 if active mask[idx]=1.
REQ-021 The seg decode SHALL be:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000
- 4=0011001, 5=0010010, 6=0000010, 7=1111000
- 8=0000000, 9=0010000, A=0001000, b=0000011
- C=1000110, d=0100001, E=0000110, F=0001110
REQ-022 At most one an bit SHALL be 0 in any cycle.

Reset
REQ-023 When reset=0, asynchronously:
- cnt, idx, staging, active, mask and pending SHALL be 0.
- an=1111, seg=1111111, dp=1, frame_done=0.
REQ-024 After reset deasserts, scanning SHALL start at idx=0, cnt=0, with the guard interval applied first.
REQ-025 A reset mid-frame SHALL discard pending and staged data, and no frame_done pulse SHALL be emitted.

Verification (REFRESH_DIV=8, GUARD=2)
REQ-026 Release reset, idle 40 cycles -> an sequence per 8-cycle slot is 1111,1111, then 1110 x6, then 1101, 1011, 0111 in the next slots; seg is 1000000 whenever an!=1111; frame_done pulses every 32 cycles.
REQ-027 update with digits_in={3:4'hF,2:4'h2,1:0,0:4'hA}, blank_in=0, mid-frame -> the current frame still shows 0s; from the next frame, slot0 seg=0001000, slot1=1000000, slot2=0100100, slot3=0001110.
REQ-028 update coincident with frame_done, followed by a second update with new data -> the next frame shows the first data and the frame after shows the second data.
REQ-029 blank_in=4'b1010 with digits 8,8,8,8 -> slots 1 and 3 have an one-cold and seg=1111111; slots 0 and 2 have seg=0000000.
REQ-030 Assert reset at cnt=5 of slot 2 -> an=1111 and seg=1111111 within the same cycle, without waiting for a clk edge; after release, scanning restarts at slot 0 with blank data.
REQ-031 Every cycle of every test, a checker asserts that an has at most one zero and dp=1.
